// File: rtl/pipe_collision_score_pkg.sv
// Shared encodings and playfield constants for the bird/pipe game datapath.
// Used by the pipe movers, the renderer and the collision/score block.
package pipe_collision_score_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHit  = 2'd2;
    localparam logic [1:0] StOver = 2'd3;

    localparam int unsigned PLAY_MIN_Y = 45;
    localparam int unsigned PLAY_MAX_Y = 420;

    typedef logic [9:0]  coord_t;
    typedef logic [10:0] coord_ext_t;

    // All geometry compares run at 11 bits so box edges (x + w) cannot wrap.
    function automatic coord_ext_t ext11(input coord_t v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/pipe_collision_score_if.sv
// Pipe-coordinate bus: bird box plus the two pipe rectangles, driven by the movers
// (master) and sampled by the collision/score block (slave).
interface pipe_collision_score_if;
    import pipe_collision_score_pkg::*;

    coord_t bird_x;
    coord_t bird_y;
    coord_t p1_l;
    coord_t p1_r;
    coord_t p1_t;
    coord_t p1_b;
    coord_t p2_l;
    coord_t p2_r;
    coord_t p2_t;
    coord_t p2_b;

    modport master (
        output bird_x, bird_y,
        output p1_l, p1_r, p1_t, p1_b,
        output p2_l, p2_r, p2_t, p2_b
    );

    modport slave (
        input bird_x, bird_y,
        input p1_l, p1_r, p1_t, p1_b,
        input p2_l, p2_r, p2_t, p2_b
    );

endinterface

// File: rtl/pipe_collision_score_bcd_counter4.sv
// Four-digit BCD score register: adds 1 or 2 per update, synchronous clear,
// saturates at 9999 and pulses done only when the value actually advances.
module pipe_collision_score_bcd_counter4 (
    input  logic        system_clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        inc1,
    input  logic        inc2,
    output logic [15:0] value,
    output logic        done
);

    logic [15:0] value_d;
    logic [15:0] sum;
    logic [1:0]  amount;
    logic        carry_out;
    logic        saturated;
    logic        bump;

    always_comb begin
        logic [4:0] digit;
        logic [1:0] carry;
        digit  = '0;
        amount = inc2 ? 2'd2 : (inc1 ? 2'd1 : 2'd0);
        carry  = amount;
        sum    = '0;
        for (int d = 0; d < 4; d++) begin
            digit = {1'b0, value[4*d +: 4]} + {3'b000, carry};
            if (digit > 5'd9) begin
                sum[4*d +: 4] = 4'(digit - 5'd10);
                carry         = 2'd1;
            end else begin
                sum[4*d +: 4] = digit[3:0];
                carry         = 2'd0;
            end
        end
        carry_out = carry[0];

        saturated = (value == 16'h9999);
        bump      = (amount != 2'd0) && !saturated;

        // 9998 + 2 overflows the top digit; clamp instead of wrapping to 0000.
        if (clear) begin
            value_d = '0;
        end else if (bump) begin
            value_d = carry_out ? 16'h9999 : sum;
        end else begin
            value_d = value;
        end
    end

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
            done  <= 1'b0;
        end else begin
            value <= value_d;
            done  <= !clear && bump;
        end
    end

endmodule

// File: rtl/pipe_collision_score.sv
// Consumer end of the pipe-coordinate bus: registers bird/pipe geometry, detects hits,
// counts passed pipes and runs the IDLE/RUN/HIT/OVER game state machine.
module pipe_collision_score
    import pipe_collision_score_pkg::*;
#(
    parameter int unsigned BIRD_W   = 17,
    parameter int unsigned BIRD_H   = 12,
    parameter int unsigned GAP_H    = 90,
    parameter int unsigned MIN_Y    = PLAY_MIN_Y,
    parameter int unsigned MAX_Y    = PLAY_MAX_Y,
    parameter int unsigned HIT_HOLD = 8
) (
    input  logic                         system_clk,
    input  logic                         reset_n,
    input  logic                         game_tick,
    input  logic                         start,
    pipe_collision_score_if.slave        pipe_if,
    output logic                         running,
    output logic                         collide,
    output logic                         game_over,
    output logic [15:0]                  score_bcd,
    output logic                         score_pulse
);

    localparam coord_ext_t BirdW = coord_ext_t'(BIRD_W);
    localparam coord_ext_t BirdH = coord_ext_t'(BIRD_H);
    localparam coord_ext_t GapH  = coord_ext_t'(GAP_H);
    localparam coord_ext_t MinY  = coord_ext_t'(MIN_Y);
    localparam coord_ext_t MaxY  = coord_ext_t'(MAX_Y);

    localparam int unsigned      HoldW    = (HIT_HOLD > 2) ? $clog2(HIT_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HIT_HOLD - 1);

    // Input sample stage: every decision below sees inputs one cycle late.
    logic   tick_q;
    logic   start_q;
    logic   start_prev_q;
    coord_t bird_x_q;
    coord_t bird_y_q;
    coord_t pl_q      [2];
    coord_t pr_q      [2];
    coord_t pb_q      [2];
    coord_t pl_prev_q [2];

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q       <= 1'b0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            bird_x_q     <= '0;
            bird_y_q     <= '0;
            for (int k = 0; k < 2; k++) begin
                pl_q[k]      <= '0;
                pr_q[k]      <= '0;
                pb_q[k]      <= '0;
                pl_prev_q[k] <= '0;
            end
        end else begin
            tick_q       <= game_tick;
            start_q      <= start;
            start_prev_q <= start_q;
            bird_x_q     <= pipe_if.bird_x;
            bird_y_q     <= pipe_if.bird_y;
            pl_q[0]      <= pipe_if.p1_l;
            pr_q[0]      <= pipe_if.p1_r;
            pb_q[0]      <= pipe_if.p1_b;
            pl_q[1]      <= pipe_if.p2_l;
            pr_q[1]      <= pipe_if.p2_r;
            pb_q[1]      <= pipe_if.p2_b;
            pl_prev_q    <= pl_q;
        end
    end

    logic       start_rise;
    coord_ext_t bird_x_x;
    coord_ext_t bird_y_x;
    coord_ext_t bird_bot_x;
    logic       ceiling_hit;
    logic       ground_hit;

    assign start_rise  = start_q && !start_prev_q;
    assign bird_x_x    = ext11(bird_x_q);
    assign bird_y_x    = ext11(bird_y_q);
    assign bird_bot_x  = bird_y_x + BirdH;
    assign ceiling_hit = bird_y_x < MinY;
    assign ground_hit  = bird_bot_x > MaxY;

    logic [1:0] armed_q;
    logic [1:0] armed_d;
    logic [1:0] pipe_hit;
    logic [1:0] pipe_pass;
    logic [1:0] pipe_rearm;

    for (genvar k = 0; k < 2; k++) begin : g_pipe
        coord_ext_t l_x;
        coord_ext_t r_x;
        coord_ext_t b_x;
        logic       x_overlap;
        logic       in_gap;

        assign l_x       = ext11(pl_q[k]);
        assign r_x       = ext11(pr_q[k]);
        assign b_x       = ext11(pb_q[k]);
        assign x_overlap = (bird_x_x + BirdW > l_x) && (bird_x_x < r_x);
        assign in_gap    = (bird_y_x >= b_x) && (bird_bot_x <= b_x + GapH);

        assign pipe_hit[k]   = x_overlap && !in_gap;
        assign pipe_pass[k]  = armed_q[k] && (r_x < bird_x_x);
        // A mover wrapping back to the right edge is the only way pk_l increases.
        assign pipe_rearm[k] = pl_q[k] > pl_prev_q[k];
    end

    logic       any_hit;
    logic [1:0] pass_tick;

    assign any_hit   = ceiling_hit || ground_hit || (|pipe_hit);
    assign pass_tick = pipe_pass & {2{tick_q}};

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [HoldW-1:0] hold_q;
    logic [HoldW-1:0] hold_d;
    logic             collide_d;
    logic             score_clear;
    logic             score_inc1;
    logic             score_inc2;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        armed_d     = armed_q;
        collide_d   = 1'b0;
        score_clear = 1'b0;
        score_inc1  = 1'b0;
        score_inc2  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d     = StRun;
                    score_clear = 1'b1;
                end
            end
            StRun: begin
                // A hit on the same tick as a pass suppresses the score.
                if (tick_q && any_hit) begin
                    state_d   = StHit;
                    hold_d    = '0;
                    collide_d = 1'b1;
                end else begin
                    armed_d    = (armed_q | pipe_rearm) & ~pass_tick;
                    score_inc1 = ^pass_tick;
                    score_inc2 = &pass_tick;
                end
            end
            StHit: begin
                if (tick_q) begin
                    if (hold_q == HoldLast) begin
                        state_d = StOver;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            StOver: begin
                if (start_rise) begin
                    state_d     = StRun;
                    score_clear = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            armed_q   <= 2'b11;
            running   <= 1'b0;
            collide   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            armed_q   <= armed_d;
            running   <= (state_d == StRun);
            collide   <= collide_d;
            game_over <= (state_d == StOver);
        end
    end

    pipe_collision_score_bcd_counter4 u_score (
        .system_clk (system_clk),
        .reset_n    (reset_n),
        .clear      (score_clear),
        .inc1       (score_inc1),
        .inc2       (score_inc2),
        .value      (score_bcd),
        .done       (score_pulse)
    );

endmodule

// File: tb/tb_pipe_collision_score.sv
// Directed bench for pipe_collision_score: hit detection, pipe pass scoring,
// BCD saturation and the IDLE/RUN/HIT/OVER sequencing.
module tb_pipe_collision_score;

    logic        system_clk;
    logic        reset_n;
    logic        game_tick;
    logic        start;
    logic        running;
    logic        collide;
    logic        game_over;
    logic [15:0] score_bcd;
    logic        score_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] score;
        logic        pulse;
    } exp_t;

    exp_t sb_q[$];

    pipe_collision_score_if pif ();

    pipe_collision_score dut (
        .system_clk  (system_clk),
        .reset_n     (reset_n),
        .game_tick   (game_tick),
        .start       (start),
        .pipe_if     (pif),
        .running     (running),
        .collide     (collide),
        .game_over   (game_over),
        .score_bcd   (score_bcd),
        .score_pulse (score_pulse)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge system_clk);
            #1;
        end
    endtask

    // Drive a one-cycle tick; returns once the resulting registered outputs are visible.
    task automatic tick_pulse();
        game_tick = 1'b1;
        cyc(1);
        game_tick = 1'b0;
        cyc(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [15:0] score, input logic pulse);
        exp_t e;
        e.score = score;
        e.pulse = pulse;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_score"}, 32'(score_bcd), 32'(e.score));
            check({tag, "_pulse"}, 32'(score_pulse), 32'(e.pulse));
        end
    endtask

    task automatic set_p1(input int l, input int r);
        pif.p1_l = 10'(l);
        pif.p1_r = 10'(r);
    endtask

    task automatic set_p2(input int l, input int r);
        pif.p2_l = 10'(l);
        pif.p2_r = 10'(r);
    endtask

    task automatic start_edge();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset_n    = 1'b0;
        game_tick  = 1'b0;
        start      = 1'b0;
        pif.bird_x = 10'd60;
        pif.bird_y = 10'd150;
        pif.p1_t   = 10'd45;
        pif.p2_t   = 10'd45;
        pif.p1_b   = 10'd130;
        pif.p2_b   = 10'd130;
        set_p1(50, 91);
        set_p2(300, 340);

        // Reset state
        cyc(3);
        check("rst_running", 32'(running), 0);
        check("rst_collide", 32'(collide), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_score", 32'(score_bcd), 0);
        check("rst_pulse", 32'(score_pulse), 0);
        reset_n = 1'b1;
        cyc(2);

        // Start edge reaches running after two cycles
        start = 1'b1;
        cyc(1);
        check("start_lat1", 32'(running), 0);
        cyc(1);
        check("start_lat2", 32'(running), 1);
        start = 1'b0;
        cyc(2);

        // Bird inside p1 gap: no hit; then above gap bottom: hit
        tick_pulse();
        check("gap_safe_collide", 32'(collide), 0);
        check("gap_safe_running", 32'(running), 1);
        pif.bird_y = 10'd100;
        tick_pulse();
        check("pipe_hit_collide", 32'(collide), 1);
        check("pipe_hit_running", 32'(running), 0);
        cyc(1);
        check("collide_one_cycle", 32'(collide), 0);
        repeat (7) tick_pulse();
        check("hold_7_ticks", 32'(game_over), 0);
        tick_pulse();
        check("hold_8_ticks", 32'(game_over), 1);

        // Restart from OVER
        pif.bird_y = 10'd150;
        start_edge();
        check("restart_running", 32'(running), 1);
        sb_push(16'h0000, 1'b0);
        sb_check("restart");

        // Single pipe passes and re-arming
        set_p1(50, 61);
        tick_pulse();
        sb_push(16'h0000, 1'b0);
        sb_check("p1_r61");
        set_p1(50, 59);
        tick_pulse();
        sb_push(16'h0001, 1'b1);
        sb_check("p1_pass1");
        for (int i = 0; i < 5; i++) begin
            tick_pulse();
            sb_push(16'h0001, 1'b0);
            sb_check("p1_disarmed");
        end
        set_p1(320, 360);
        cyc(2);
        set_p1(50, 59);
        tick_pulse();
        sb_push(16'h0002, 1'b1);
        sb_check("p1_pass2");
        set_p1(320, 360);
        cyc(2);
        set_p1(50, 59);
        tick_pulse();
        sb_push(16'h0003, 1'b1);
        sb_check("p1_pass3");

        // Both pipes pass on one tick
        set_p1(320, 360);
        cyc(2);
        set_p1(10, 20);
        set_p2(10, 20);
        tick_pulse();
        sb_push(16'h0005, 1'b1);
        sb_check("double_pass");
        cyc(1);
        sb_push(16'h0005, 1'b0);
        sb_check("double_pass_single_pulse");

        // Ground hit on the same tick as a pass
        set_p1(320, 360);
        cyc(2);
        set_p1(10, 20);
        pif.bird_y = 10'd430;
        tick_pulse();
        check("ground_collide", 32'(collide), 1);
        sb_push(16'h0005, 1'b0);
        sb_check("ground_no_score");

        // Start in HIT is ignored
        start_edge();
        cyc(2);
        check("hit_start_running", 32'(running), 0);
        check("hit_start_over", 32'(game_over), 0);
        repeat (8) tick_pulse();
        check("hit_to_over", 32'(game_over), 1);
        sb_push(16'h0005, 1'b0);
        sb_check("over_frozen");

        // Restart clears the score
        pif.bird_y = 10'd150;
        set_p2(200, 240);
        start_edge();
        check("over_restart_running", 32'(running), 1);
        sb_push(16'h0000, 1'b0);
        sb_check("over_restart");

        // Climb to 9999: one single pass then double passes
        set_p1(320, 360);
        cyc(2);
        set_p1(10, 20);
        tick_pulse();
        sb_push(16'h0001, 1'b1);
        sb_check("climb_start");
        for (int i = 0; i < 4999; i++) begin
            set_p1(300, 330);
            set_p2(300, 330);
            game_tick = 1'b0;
            cyc(1);
            set_p1(10, 20);
            set_p2(10, 20);
            game_tick = 1'b1;
            cyc(1);
        end
        game_tick = 1'b0;
        set_p1(300, 330);
        set_p2(300, 330);
        cyc(1);
        sb_push(16'h9999, 1'b1);
        sb_check("reach_9999");
        cyc(1);
        set_p1(10, 20);
        set_p2(10, 20);
        tick_pulse();
        sb_push(16'h9999, 1'b0);
        sb_check("saturate_9999");

        // Async reset in the middle of HIT
        pif.bird_y = 10'd430;
        tick_pulse();
        check("late_hit_collide", 32'(collide), 1);
        tick_pulse();
        @(posedge system_clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_running", 32'(running), 0);
        check("async_collide", 32'(collide), 0);
        check("async_game_over", 32'(game_over), 0);
        check("async_score", 32'(score_bcd), 0);
        check("async_pulse", 32'(score_pulse), 0);
        cyc(2);
        reset_n = 1'b1;
        tick_pulse();
        check("idle_after_reset", 32'(running), 0);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
